// File: rtl/net_pkg.sv
// Shared photonic-network types used by the transmit scheduler and its FIFOs.
package net_pkg;

  typedef logic [31:0] packet_t;
  typedef logic [15:0] node_t;

  localparam packet_t IDLE_PACKET = 32'h0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage is not reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/photonic_tx_scheduler.sv
// Buffers control and data words and launches at most one per TDMA slot owned
// by this node, control first.
module photonic_tx_scheduler
  import net_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SLOT_CYCLES = 2,
  parameter int DROP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  node_t             node_id,
  input  node_t             max_node,
  input  packet_t           control_tx_packet,
  input  packet_t           data_tx_packet,
  output logic              ctrl_fifo_full,
  output logic              data_fifo_full,
  output logic              net_tx_valid,
  output logic              net_tx_is_ctrl,
  output node_t             net_tx_src,
  output packet_t           net_tx_packet,
  output node_t             slot_owner,
  output logic [DROP_W-1:0] ctrl_drop_cnt,
  output logic [DROP_W-1:0] data_drop_cnt
);

  localparam int FA    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CYCLE    = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CYC_ONE       = CNT_W'(1);
  localparam logic [FA:0]       FIFO_FULL_CNT = (FA+1)'(FIFO_DEPTH);
  localparam logic [DROP_W-1:0] DROP_ONE      = DROP_W'(1);

  logic [CNT_W-1:0]  r_cycle_cnt;
  node_t             r_slot_owner;
  logic              r_tx_valid;
  logic              r_tx_is_ctrl;
  node_t             r_tx_src;
  packet_t           r_tx_packet;
  logic [DROP_W-1:0] r_ctrl_drop;
  logic [DROP_W-1:0] r_data_drop;

  node_t             w_eff_max;
  logic              w_slot_wrap;
  logic              w_slot_start;
  logic              w_push_ctrl;
  logic              w_push_data;
  logic              w_pop_ctrl;
  logic              w_pop_data;
  logic              w_ctrl_drop;
  logic              w_data_drop;
  packet_t           w_ctrl_head;
  packet_t           w_data_head;
  logic              w_ctrl_full;
  logic              w_data_full;
  logic              w_ctrl_empty;
  logic              w_data_empty;
  logic [FA:0]       w_ctrl_count;
  logic [FA:0]       w_data_count;

  assign w_eff_max    = (max_node == 16'd0) ? 16'd1 : max_node;
  assign w_slot_wrap  = (r_cycle_cnt == LAST_CYCLE);
  // A node index outside the frame never owns a launch, even transiently.
  assign w_slot_start = (r_slot_owner == node_id) && (r_cycle_cnt == '0) &&
                        (node_id < w_eff_max);

  assign w_push_ctrl = (control_tx_packet != IDLE_PACKET);
  assign w_push_data = (data_tx_packet != IDLE_PACKET);
  assign w_pop_ctrl  = w_slot_start && !w_ctrl_empty;
  assign w_pop_data  = w_slot_start && w_ctrl_empty && !w_data_empty;
  assign w_ctrl_drop = w_push_ctrl && w_ctrl_full && !w_pop_ctrl;
  assign w_data_drop = w_push_data && w_data_full && !w_pop_data;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_ctrl_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_ctrl),
    .pop   (w_pop_ctrl),
    .din   (control_tx_packet),
    .dout  (w_ctrl_head),
    .full  (w_ctrl_full),
    .empty (w_ctrl_empty),
    .count (w_ctrl_count)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_data),
    .pop   (w_pop_data),
    .din   (data_tx_packet),
    .dout  (w_data_head),
    .full  (w_data_full),
    .empty (w_data_empty),
    .count (w_data_count)
  );

  // The frame length is sampled only on a slot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt  <= '0;
      r_slot_owner <= '0;
    end else if (w_slot_wrap) begin
      r_cycle_cnt <= '0;
      if (r_slot_owner >= w_eff_max - 16'd1) begin
        r_slot_owner <= '0;
      end else begin
        r_slot_owner <= r_slot_owner + 16'd1;
      end
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CYC_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_valid   <= 1'b0;
      r_tx_is_ctrl <= 1'b0;
      r_tx_src     <= '0;
      r_tx_packet  <= '0;
    end else begin
      r_tx_valid <= w_pop_ctrl || w_pop_data;
      if (w_pop_ctrl || w_pop_data) begin
        r_tx_is_ctrl <= w_pop_ctrl;
        r_tx_src     <= node_id;
        r_tx_packet  <= w_pop_ctrl ? w_ctrl_head : w_data_head;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl_drop <= '0;
      r_data_drop <= '0;
    end else begin
      if (w_ctrl_drop && (r_ctrl_drop != '1)) begin
        r_ctrl_drop <= r_ctrl_drop + DROP_ONE;
      end
      if (w_data_drop && (r_data_drop != '1)) begin
        r_data_drop <= r_data_drop + DROP_ONE;
      end
    end
  end

  assign ctrl_fifo_full = (w_ctrl_count == FIFO_FULL_CNT);
  assign data_fifo_full = (w_data_count == FIFO_FULL_CNT);
  assign net_tx_valid   = r_tx_valid;
  assign net_tx_is_ctrl = r_tx_is_ctrl;
  assign net_tx_src     = r_tx_src;
  assign net_tx_packet  = r_tx_packet;
  assign slot_owner     = r_slot_owner;
  assign ctrl_drop_cnt  = r_ctrl_drop;
  assign data_drop_cnt  = r_data_drop;

endmodule

// File: tb/tb_photonic_tx_scheduler.sv
// Directed bench for photonic_tx_scheduler: a per-cycle vector table for the
// basic and priority launches, then hand sequences for the corner cases.
module tb_photonic_tx_scheduler;
  import net_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  node_t      nodeId = '0;
  node_t      maxNode = '0;
  packet_t    ctrlIn = '0;
  packet_t    dataIn = '0;
  logic       ctrlFull;
  logic       dataFull;
  logic       txValid;
  logic       txIsCtrl;
  node_t      txSrc;
  packet_t    txPacket;
  node_t      slotOwner;
  logic [7:0] ctrlDrop;
  logic [7:0] dataDrop;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    packet_t ctrl;
    packet_t data;
    logic    expValid;
    logic    expIsCtrl;
    packet_t expPacket;
    node_t   expSrc;
    node_t   expOwner;
  } vec_t;

  vec_t vecs [1:28];

  photonic_tx_scheduler #(.FIFO_DEPTH(8), .SLOT_CYCLES(2), .DROP_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .node_id           (nodeId),
    .max_node          (maxNode),
    .control_tx_packet (ctrlIn),
    .data_tx_packet    (dataIn),
    .ctrl_fifo_full    (ctrlFull),
    .data_fifo_full    (dataFull),
    .net_tx_valid      (txValid),
    .net_tx_is_ctrl    (txIsCtrl),
    .net_tx_src        (txSrc),
    .net_tx_packet     (txPacket),
    .slot_owner        (slotOwner),
    .ctrl_drop_cnt     (ctrlDrop),
    .data_drop_cnt     (dataDrop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives both streams for the coming edge, then samples 1 ns after it.
  task automatic applyStimulus(input packet_t c, input packet_t d);
    ctrlIn = c;
    dataIn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input node_t n, input node_t m);
    rst     = 1'b1;
    ctrlIn  = '0;
    dataIn  = '0;
    nodeId  = n;
    maxNode = m;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " valid"}, 32'(txValid), 32'd0);
    checkOutput({tag, " is_ctrl"}, 32'(txIsCtrl), 32'd0);
    checkOutput({tag, " packet"}, txPacket, 32'd0);
    checkOutput({tag, " src"}, 32'(txSrc), 32'd0);
    checkOutput({tag, " owner"}, 32'(slotOwner), 32'd0);
    checkOutput({tag, " ctrl_full"}, 32'(ctrlFull), 32'd0);
    checkOutput({tag, " data_full"}, 32'(dataFull), 32'd0);
    checkOutput({tag, " ctrl_drop"}, 32'(ctrlDrop), 32'd0);
    checkOutput({tag, " data_drop"}, 32'(dataDrop), 32'd0);
  endtask

  initial begin
    int launches;

    // Node 1 of 4, two cycles per slot: node 1 pops on edges 3, 11, 19, 27.
    for (int k = 1; k <= 28; k++) begin
      vecs[k].ctrl      = '0;
      vecs[k].data      = '0;
      vecs[k].expValid  = (k == 3) || (k == 19) || (k == 27);
      vecs[k].expIsCtrl = (k >= 3) && (k < 27);
      vecs[k].expPacket = (k < 3)  ? 32'h0 :
                          (k < 19) ? 32'h0001FFFF :
                          (k < 27) ? 32'h00020001 : 32'hA5A5A5A5;
      vecs[k].expSrc    = (k < 3) ? 16'd0 : 16'd1;
      vecs[k].expOwner  = node_t'((k / 2) % 4);
    end
    vecs[1].ctrl  = 32'h0001FFFF;
    vecs[12].data = 32'hA5A5A5A5;
    vecs[13].ctrl = 32'h00020001;

    doReset(16'd1, 16'd4);
    checkIdleOutputs("reset");

    for (int k = 1; k <= 28; k++) begin
      applyStimulus(vecs[k].ctrl, vecs[k].data);
      checkOutput($sformatf("v%0d valid", k), 32'(txValid), 32'(vecs[k].expValid));
      checkOutput($sformatf("v%0d is_ctrl", k), 32'(txIsCtrl), 32'(vecs[k].expIsCtrl));
      checkOutput($sformatf("v%0d packet", k), txPacket, vecs[k].expPacket);
      checkOutput($sformatf("v%0d src", k), 32'(txSrc), 32'(vecs[k].expSrc));
      checkOutput($sformatf("v%0d owner", k), 32'(slotOwner), 32'(vecs[k].expOwner));
    end

    // Overflow on a node outside the frame: 11 pushes, 8 kept, 3 dropped.
    doReset(16'd5, 16'd4);
    launches = 0;
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(packet_t'(k), '0);
      if (txValid) launches++;
      if (k == 7) checkOutput("ovf full after 7", 32'(ctrlFull), 32'd0);
      if (k == 8) checkOutput("ovf full after 8", 32'(ctrlFull), 32'd1);
      if (k == 9) checkOutput("ovf drop after 9", 32'(ctrlDrop), 32'd1);
    end
    for (int k = 12; k <= 24; k++) begin
      applyStimulus('0, '0);
      if (txValid) launches++;
    end
    checkOutput("ovf drop count", 32'(ctrlDrop), 32'd3);
    checkOutput("ovf data drop", 32'(dataDrop), 32'd0);
    checkOutput("ovf still full", 32'(ctrlFull), 32'd1);
    checkOutput("ovf no launch", 32'(launches), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("ovf reset full", 32'(ctrlFull), 32'd0);
    checkOutput("ovf reset drop", 32'(ctrlDrop), 32'd0);

    // Full FIFO at a slot start with a push on the same edge.
    doReset(16'd5, 16'd4);
    for (int k = 1; k <= 8; k++) applyStimulus(packet_t'(k), '0);
    checkOutput("pp full before", 32'(ctrlFull), 32'd1);
    nodeId = 16'd1;
    applyStimulus('0, '0);
    applyStimulus('0, '0);
    applyStimulus(32'h00000099, '0);
    checkOutput("pp valid", 32'(txValid), 32'd1);
    checkOutput("pp packet", txPacket, 32'h00000001);
    checkOutput("pp full after", 32'(ctrlFull), 32'd1);
    checkOutput("pp drop", 32'(ctrlDrop), 32'd0);
    applyStimulus('0, '0);
    checkOutput("pp pulse width", 32'(txValid), 32'd0);
    checkOutput("pp packet hold", txPacket, 32'h00000001);

    // max_node=0 degenerates to a one-node frame owned by node 0.
    doReset(16'd0, 16'd0);
    for (int k = 1; k <= 8; k++) begin
      packet_t d;
      logic    expV;
      packet_t expP;
      d    = (k == 1) ? 32'h11 : (k == 2) ? 32'h22 : (k == 3) ? 32'h33 : 32'h0;
      expV = (k == 3) || (k == 5) || (k == 7);
      expP = (k < 3) ? 32'h0 : (k < 5) ? 32'h11 : (k < 7) ? 32'h22 : 32'h33;
      applyStimulus('0, d);
      checkOutput($sformatf("m0 e%0d owner", k), 32'(slotOwner), 32'd0);
      checkOutput($sformatf("m0 e%0d valid", k), 32'(txValid), 32'(expV));
      checkOutput($sformatf("m0 e%0d packet", k), txPacket, expP);
    end
    checkOutput("m0 is_ctrl", 32'(txIsCtrl), 32'd0);
    maxNode = 16'd3;
    for (int k = 9; k <= 14; k++) begin
      applyStimulus('0, '0);
      if (k == 10) checkOutput("m3 owner e10", 32'(slotOwner), 32'd1);
      if (k == 12) checkOutput("m3 owner e12", 32'(slotOwner), 32'd2);
      if (k == 14) checkOutput("m3 owner e14", 32'(slotOwner), 32'd0);
    end

    // Async reset while node 1 is launching with three words queued.
    doReset(16'd1, 16'd4);
    for (int k = 1; k <= 11; k++) begin
      packet_t c;
      c = (k == 4) ? 32'hC1 : (k == 5) ? 32'hC2 : (k == 6) ? 32'hC3 : 32'h0;
      applyStimulus(c, '0);
    end
    checkOutput("ar launch valid", 32'(txValid), 32'd1);
    checkOutput("ar launch packet", txPacket, 32'hC1);
    #2;
    rst = 1'b1;
    #1;
    checkIdleOutputs("ar async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    launches = 0;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus('0, '0);
      if (txValid) launches++;
    end
    checkOutput("ar no launch after reset", 32'(launches), 32'd0);
    applyStimulus(32'hC4, '0);
    applyStimulus('0, '0);
    applyStimulus('0, '0);
    checkOutput("ar relaunch valid", 32'(txValid), 32'd1);
    checkOutput("ar relaunch packet", txPacket, 32'hC4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/photonic_tx_scheduler.md
Name: photonic_tx_scheduler

Overview:
- Downstream neighbour of `computer`. Consumes its `control_tx_packet` and `data_tx_packet` outputs and buffers each stream in its own FIFO.
- Drains the FIFOs onto the shared photonic bus under round-robin TDMA. Node n may launch exactly one packet per frame, in slot n.
- Control traffic has strict priority over data traffic.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO (power of two, ≥2).
- SLOT_CYCLES, 2, clock cycles per TDMA slot (≥1).
- DROP_W, 8, width of each saturating drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- node_id  in  16  this node's index, 0..max_node-1
- max_node  in  16  number of nodes in the TDMA frame
- control_tx_packet  in  32  control word from computer; 32'h0 = idle, non-zero = valid for that cycle
- data_tx_packet  in  32  data word from computer; 32'h0 = idle, non-zero = valid for that cycle
- ctrl_fifo_full  out  1  control FIFO full
- data_fifo_full  out  1  data FIFO full
- net_tx_valid  out  1  single-cycle launch strobe
- net_tx_is_ctrl  out  1  1 = launched word is a control packet
- net_tx_src  out  16  node_id registered with the launch
- net_tx_packet  out  32  launched word
- slot_owner  out  16  node index owning the current slot
- ctrl_drop_cnt  out  DROP_W  control words lost to overflow
- data_drop_cnt  out  DROP_W  data words lost to overflow

Behaviour:
- Reset (async assert, sync-clean deassert):
  - All outputs 0; slot_owner = 0; cycle_cnt = 0.
  - FIFOs empty; drop counters 0.
- Ingress:
  - Every rising edge with a non-zero input pushes that word into its FIFO, one word per cycle per stream.
  - A value held non-zero for k cycles pushes k times. Duplicate suppression is the producer's job.
  - Push when full and no pop on the same edge: word dropped, FIFO unchanged, matching drop counter +1, saturating at all-ones.
  - Push and pop on the same edge while full: push accepted, no drop.
- Slot timer:
  - cycle_cnt counts 0..SLOT_CYCLES-1.
  - On wrap, slot_owner increments; when slot_owner is ≥ eff_max-1 it wraps to 0.
  - eff_max = (max_node == 0) ? 1 : max_node.
  - max_node changes take effect at the next wrap.
- Launch decision, evaluated at each edge from pre-edge state. When slot_owner == node_id and cycle_cnt == 0:
  - If the control FIFO is non-empty: pop control; next cycle net_tx_valid=1, net_tx_is_ctrl=1, net_tx_packet=head, net_tx_src=node_id.
  - Else if the data FIFO is non-empty: pop data; same outputs with net_tx_is_ctrl=0.
  - Else nothing is launched.
- Launch limits and output hold:
  - At most one launch per slot.
  - net_tx_valid is high for exactly one cycle.
  - net_tx_packet, net_tx_is_ctrl and net_tx_src hold their last values while net_tx_valid=0.
- Latency: a word pushed at edge E can be popped at the earliest at edge E+1, if that edge is a slot start. Bus appearance is the cycle after the pop.
- node_id ≥ eff_max: the node never launches. FIFOs fill and overflow counters run.
- Reset mid-slot or mid-launch: everything clears immediately, including any pending strobe. Buffered words are lost.
- Full flags are combinational from the FIFO counts (count == FIFO_DEPTH).

Decomposition:
- Package `net_pkg`:
  - typedef `packet_t` (logic [31:0])
  - typedef `node_t` (logic [15:0])
  - constant `IDLE_PACKET` = 32'h0
- Sub-module `sync_fifo`:
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, din, dout (first-word-fall-through), full, empty, count.
  - Same clock and async reset.
  - Instanced twice, once per stream.

Test Plan:
- Basic control launch (node_id=1, max_node=4, SLOT_CYCLES=2): release reset, drive control_tx_packet=32'h0001FFFF for 1 cycle → one net_tx_valid pulse in the cycle after the first slot_owner==1 slot start, with net_tx_is_ctrl=1, net_tx_packet=32'h0001FFFF, net_tx_src=1. Exactly one launch per 8-cycle frame; none when the FIFO is empty.
- Priority: push data 32'hA5A5A5A5, then control 32'h00020001, both before node 1's slot → control launched in frame 1, data in frame 2.
- Overflow: node_id=5, max_node=4, drive 11 consecutive control words 1..11 → ctrl_fifo_full=1 after 8 pushes, ctrl_drop_cnt=3, net_tx_valid never asserts.
- Full with simultaneous push/pop: FIFO full at slot start with a push that cycle → word accepted, count stays 8, drop counter unchanged.
- Frame wrap and max_node=0: max_node=0 → slot_owner stuck at 0; node 0 launches every SLOT_CYCLES. Switching max_node to 3 → slot_owner sequence 0,1,2,0.
- Async reset mid-operation: assert rst between edges during node 1's slot with 3 queued words → outputs and counters 0 immediately, no launch after deassertion until new pushes arrive.
